// File: rtl/serial_pattern_tx_pkg.sv
// Shared types and default sizing for the serial pattern transmitter.
package serial_pattern_tx_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_LEN_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_e;

endpackage

// File: rtl/piso_shreg.sv
// Parallel-in/serial-out shift register, MSB first with zero fill.
module piso_shreg
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             msb_o
);

    logic [WIDTH-1:0] shreg_q;
    logic [WIDTH-1:0] shreg_d;

    // Clear wins so the line drops to 0 right after the last payload bit.
    always_comb begin
        shreg_d = shreg_q;
        if (clear_i) begin
            shreg_d = '0;
        end else if (load_i) begin
            shreg_d = data_i;
        end else if (shift_i) begin
            shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial bit-stream transmitter: load a word, shift it out MSB-first, then a one-cycle zero gap with done.
module serial_pattern_tx
    import serial_pattern_tx_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned LEN_W = DEFAULT_LEN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             out,
    output logic             out_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] len_clamped_c;
    logic             sh_load, sh_shift, sh_clear;

    assign len_clamped_c = (len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : len;

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_clear = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_valid) begin
                    cnt_d = len_clamped_c;
                    if (len_clamped_c != '0) begin
                        state_d = ST_SHIFT;
                        sh_load = 1'b1;
                    end else begin
                        state_d  = ST_GAP;
                        sh_clear = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    state_d  = ST_GAP;
                    sh_clear = 1'b1;
                end else begin
                    sh_shift = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        out_valid_d = (state_d == ST_SHIFT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_GAP);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // The shift register MSB is itself a flop and is zero outside SHIFT.
    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_piso_shreg (
        .clk     (clk),
        .reset   (reset),
        .load_i  (sh_load),
        .shift_i (sh_shift),
        .clear_i (sh_clear),
        .data_i  (data),
        .msb_o   (out)
    );

    assign load_ready = (state_q == ST_IDLE);
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Directed, table-driven check of serial_pattern_tx bit order, gap/done timing and reset abort.
module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] data;
    logic [3:0] len;
    logic       out;
    logic       out_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0] data;
        logic [3:0] len;
        logic [7:0] exp_bits;
        int         exp_n;
    } vec_t;

    vec_t vecs[6];

    serial_pattern_tx #(
        .WIDTH (8),
        .LEN_W (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data       (data),
        .len        (len),
        .out        (out),
        .out_valid  (out_valid),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input logic e_out, input logic e_vld,
                            input logic e_busy, input logic e_done, input logic e_rdy);
        chk({tag, ".out"}, out, e_out);
        chk({tag, ".out_valid"}, out_valid, e_vld);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".load_ready"}, load_ready, e_rdy);
    endtask

    initial begin
        vecs[0] = '{data: 8'b1011_0010, len: 4'd8,  exp_bits: 8'b1011_0010, exp_n: 8};
        vecs[1] = '{data: 8'hE0,        len: 4'd3,  exp_bits: 8'b1110_0000, exp_n: 3};
        vecs[2] = '{data: 8'hA5,        len: 4'd0,  exp_bits: 8'b0000_0000, exp_n: 0};
        vecs[3] = '{data: 8'h5A,        len: 4'd15, exp_bits: 8'b0101_1010, exp_n: 8};
        vecs[4] = '{data: 8'hC3,        len: 4'd9,  exp_bits: 8'b1100_0011, exp_n: 8};
        vecs[5] = '{data: 8'h96,        len: 4'd5,  exp_bits: 8'b1001_0000, exp_n: 5};

        reset      = 1'b1;
        load_valid = 1'b0;
        data       = 8'h00;
        len        = 4'd0;

        #1;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Each vector: idle check + load, payload cycles with junk loads, gap cycle.
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            chk_outs($sformatf("v%0d.idle", v), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            load_valid = 1'b1;
            data       = vecs[v].data;
            len        = vecs[v].len;
            for (int k = 0; k < vecs[v].exp_n; k++) begin
                logic [7:0] eb;
                eb = vecs[v].exp_bits;
                @(negedge clk);
                chk_outs($sformatf("v%0d.bit%0d", v, k), eb[7-k], 1'b1, 1'b1, 1'b0, 1'b0);
                data = ~data;
                len  = 4'd1;
            end
            @(negedge clk);
            chk_outs($sformatf("v%0d.gap", v), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
            load_valid = 1'b0;
        end

        // Back-to-back: FF/2 then 80/1 with load_valid held high throughout.
        @(negedge clk);
        chk_outs("b2b.idle0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        load_valid = 1'b1;
        data       = 8'hFF;
        len        = 4'd2;
        @(negedge clk);
        chk_outs("b2b.w0b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        data = 8'h80;
        len  = 4'd1;
        @(negedge clk);
        chk_outs("b2b.w0b1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("b2b.gap0", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_outs("b2b.idle1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk_outs("b2b.w1b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0;
        @(negedge clk);
        chk_outs("b2b.gap1", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        chk_outs("b2b.idle2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while a 1 is on the line mid-word.
        load_valid = 1'b1;
        data       = 8'hA5;
        len        = 4'd8;
        @(negedge clk);
        chk_outs("rst.b0", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        load_valid = 1'b0;
        @(negedge clk);
        chk_outs("rst.b1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        chk_outs("rst.b2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk_outs("rst.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk_outs($sformatf("rst.after%0d", c), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
